dual_port_rom_reader: RTL

- Address-generation and read-back stage wrapped around infer_dual_port_rom (10-bit address, 12-bit data, 1-cycle registered read).
- Accepts a burst command (base address, pair count) and drives addr_a/addr_b with consecutive address pairs: A = even offset, B = odd offset.
- Captures q_a/q_b after the ROM latency and emits 24-bit words on a valid/ready stream.
- The ROM cannot be stalled, so a credit-controlled output FIFO absorbs backpressure.

---
 rtl/dual_port_rom_reader_pkg.sv | 19 +
 rtl/dual_port_rom_reader_fifo.sv | 77 +++++++
 rtl/dual_port_rom_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dual_port_rom_reader_pkg.sv
// Shared types, default widths and address helper for the ROM pair reader.
package dual_port_rom_reader_pkg;

  localparam int unsigned AW_DEF = 10;
  localparam int unsigned DW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Port-A address of pair number idx in a burst starting at base (wraps mod 2^AW).
  function automatic logic [AW_DEF-1:0] pair_addr(input logic [AW_DEF-1:0] base,
                                                  input logic [AW_DEF-1:0] idx);
    return base + {idx[AW_DEF-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/dual_port_rom_reader_fifo.sv
// Show-ahead synchronous FIFO buffering captured ROM pairs ahead of the output stream.
module rom_reader_fifo #(
  parameter int unsigned W     = 25,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             din,
  input  logic                     rd_en,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;

  // Next storage, pointer and occupancy values.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; storage cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Upstream credit accounting must never let a write reach a full buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_en && full));
    end
  end

endmodule

// File: rtl/dual_port_rom_reader.sv
// Burst address generator for a dual-port ROM with credit-controlled read-back stream.
module dual_port_rom_reader
  import dual_port_rom_reader_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_base,
  input  logic [AW-1:0]   cmd_len,
  output logic [AW-1:0]   addr_a,
  output logic [AW-1:0]   addr_b,
  input  logic [DW-1:0]   q_a,
  input  logic [DW-1:0]   q_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW = 2 * DW + 1;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [AW-1:0]       rem_q, rem_d;
  logic [AW-1:0]       addr_a_q, addr_a_d;
  logic [AW-1:0]       addr_b_q, addr_b_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;
  logic                iss_vld_q, iss_vld_d;
  logic                iss_last_q, iss_last_d;
  logic [ROM_LAT-1:0]  pv_q, pv_d;
  logic [ROM_LAT-1:0]  pl_q, pl_d;

  logic                accept, issue, pop, pop_last, fifo_wr;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [FW-1:0]       fifo_dout;

  assign accept   = cmd_valid & (state_q == IDLE);
  assign issue    = (state_q == ISSUE) && (credit_q != '0);
  assign pop      = ~fifo_empty & out_ready;
  assign pop_last = pop & fifo_dout[0];
  assign fifo_wr  = pv_q[ROM_LAT-1];

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_dout[FW-1:1];
  assign out_last  = fifo_dout[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: DRAIN ends on the pop of the word flagged last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (issue && (rem_q == '0)) state_d = DRAIN;
      DRAIN:   if (pop_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values: address issue, credits, tag pipe.
  always_comb begin
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    credit_d    = credit_q;
    iss_vld_d   = issue;
    iss_last_d  = issue && (rem_q == '0);
    pv_d        = pv_q;
    pl_d        = pl_q;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);

    if (accept) begin
      ptr_d = cmd_base;
      rem_d = cmd_len;
    end
    if (issue) begin
      addr_a_d = ptr_q;
      addr_b_d = ptr_q + AW'(1);
      ptr_d    = ptr_q + AW'(2);
      if (rem_q != '0) rem_d = rem_q - AW'(1);
    end

    case ({issue, pop})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase

    // Tag stage aligned with the address enters the pipe; its exit lines up with q.
    pv_d[0] = iss_vld_q;
    pl_d[0] = iss_last_q;
    for (int i = 1; i < int'(ROM_LAT); i++) begin
      pv_d[i] = pv_q[i-1];
      pl_d[i] = pl_q[i-1];
    end
  end

  // Datapath registers; reset drops every in-flight tag so stale ROM data is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rem_q       <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      credit_q    <= CW'(FIFO_DEPTH);
      iss_vld_q   <= 1'b0;
      iss_last_q  <= 1'b0;
      pv_q        <= '0;
      pl_q        <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      credit_q    <= credit_d;
      iss_vld_q   <= iss_vld_d;
      iss_last_q  <= iss_last_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Credits plus buffered words can never exceed the buffer size.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (32'(credit_q) + 32'(fifo_count) <= FIFO_DEPTH);
    end
  end

  rom_reader_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (fifo_wr),
    .din   ({q_b, q_a, pl_q[ROM_LAT-1]}),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
